// File: rtl/stack_ram_if.sv
// CPU data-RAM port plus debug peek and status signals for the stack RAM responder.
// There is no handshake. address_ram, wren_ram and data_ram are sampled on every rising clock edge.
// q_ram returns LATENCY edges later, and peek_data returns one edge after peek_addr.
interface stack_ram_if;
    logic [15:0] address_ram;
    logic        wren_ram;
    logic [15:0] data_ram;
    logic [15:0] q_ram;
    logic        ready;
    logic        err;
    logic [15:0] write_count;
    logic [15:0] peek_addr;
    logic [15:0] peek_data;

    modport master (
        output address_ram, wren_ram, data_ram, peek_addr,
        input  q_ram, ready, err, write_count, peek_data
    );

    modport slave (
        input  address_ram, wren_ram, data_ram, peek_addr,
        output q_ram, ready, err, write_count, peek_data
    );
endinterface

// File: rtl/stack_ram_responder.sv
// Data-RAM responder for the stack CPU: zero-fills after reset, then serves fixed-latency reads,
// writes, a debug peek port and a saturating write counter.
module stack_ram_responder #(
    parameter int ADDR_BITS = 8,
    parameter int LATENCY   = 2
) (
    input  logic       clock,
    input  logic       reset,
    stack_ram_if.slave bus,
    output logic       fsm_state
);
    localparam int DEPTH = 2 ** ADDR_BITS;

    generate
        if (LATENCY < 1 || LATENCY > 4) begin : g_bad_latency
            $error("stack_ram_responder: LATENCY must be in 1..4");
        end
    endgenerate

    typedef enum logic {CLEAR = 1'b0, RUN = 1'b1} state_t;

    state_t               state;
    logic [ADDR_BITS-1:0] clr_ptr;
    logic [15:0]          mem [DEPTH];
    logic [15:0]          pipe [LATENCY];
    logic                 ready_r;
    logic                 err_r;
    logic [15:0]          count_r;
    logic [15:0]          peek_r;

    logic                 addr_ok;
    logic                 peek_ok;
    logic                 cpu_write;
    logic [ADDR_BITS-1:0] addr_idx;
    logic [ADDR_BITS-1:0] peek_idx;
    logic [15:0]          rd_next;
    logic [15:0]          peek_next;

    // The upper address bits are used only for the range check, so out-of-range addresses never alias.
    always_comb begin
        addr_idx  = bus.address_ram[ADDR_BITS-1:0];
        peek_idx  = bus.peek_addr[ADDR_BITS-1:0];
        addr_ok   = (bus.address_ram >> ADDR_BITS) == 16'd0;
        peek_ok   = (bus.peek_addr >> ADDR_BITS) == 16'd0;
        cpu_write = (state == RUN) && bus.wren_ram && addr_ok;
        rd_next   = 16'd0;
        peek_next = 16'd0;
        if (state == RUN && addr_ok) begin
            rd_next = cpu_write ? bus.data_ram : mem[addr_idx];
        end
        if (state == RUN && peek_ok) begin
            peek_next = (cpu_write && peek_idx == addr_idx) ? bus.data_ram : mem[peek_idx];
        end
    end

    always_ff @(posedge clock) begin
        if (state == CLEAR) begin
            mem[clr_ptr] <= 16'd0;
        end else if (cpu_write) begin
            mem[addr_idx] <= bus.data_ram;
        end
    end

    // The first pipeline register loads at the sampling edge, so q_ram is LATENCY registers deep.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= CLEAR;
            clr_ptr <= '0;
            ready_r <= 1'b0;
            err_r   <= 1'b0;
            count_r <= 16'd0;
            peek_r  <= 16'd0;
            for (int i = 0; i < LATENCY; i++) begin
                pipe[i] <= 16'd0;
            end
        end else begin
            pipe[0] <= rd_next;
            for (int i = 1; i < LATENCY; i++) begin
                pipe[i] <= pipe[i-1];
            end
            peek_r <= peek_next;
            case (state)
                CLEAR: begin
                    if (bus.wren_ram) begin
                        err_r <= 1'b1;
                    end
                    clr_ptr <= clr_ptr + 1'b1;
                    if (clr_ptr == '1) begin
                        state   <= RUN;
                        ready_r <= 1'b1;
                    end
                end
                RUN: begin
                    if (!addr_ok) begin
                        err_r <= 1'b1;
                    end
                    if (cpu_write && count_r != 16'hffff) begin
                        count_r <= count_r + 16'd1;
                    end
                end
                default: state <= CLEAR;
            endcase
        end
    end

    assign bus.q_ram       = pipe[LATENCY-1];
    assign bus.ready       = ready_r;
    assign bus.err         = err_r;
    assign bus.write_count = count_r;
    assign bus.peek_data   = peek_r;
    assign fsm_state       = state;
endmodule

// File: tb/tb_stack_ram_responder.sv
// Scoreboard bench for stack_ram_responder: three instances (LATENCY 1, 2 and 4) share the same stimulus.
// A reference memory model predicts every read, peek and status value.
module tb_stack_ram_responder;
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] address_ram = 16'd0;
    logic        wren_ram = 1'b0;
    logic [15:0] data_ram = 16'd0;
    logic [15:0] peek_addr = 16'd0;
    logic        st1, st2, st4;

    always #5 clock = ~clock;

    stack_ram_if bus1();
    stack_ram_if bus2();
    stack_ram_if bus4();

    assign bus1.address_ram = address_ram;
    assign bus1.wren_ram    = wren_ram;
    assign bus1.data_ram    = data_ram;
    assign bus1.peek_addr   = peek_addr;
    assign bus2.address_ram = address_ram;
    assign bus2.wren_ram    = wren_ram;
    assign bus2.data_ram    = data_ram;
    assign bus2.peek_addr   = peek_addr;
    assign bus4.address_ram = address_ram;
    assign bus4.wren_ram    = wren_ram;
    assign bus4.data_ram    = data_ram;
    assign bus4.peek_addr   = peek_addr;

    stack_ram_responder #(.ADDR_BITS(8), .LATENCY(1)) dut1 (.clock(clock), .reset(reset), .bus(bus1), .fsm_state(st1));
    stack_ram_responder #(.ADDR_BITS(8), .LATENCY(2)) dut2 (.clock(clock), .reset(reset), .bus(bus2), .fsm_state(st2));
    stack_ram_responder #(.ADDR_BITS(8), .LATENCY(4)) dut4 (.clock(clock), .reset(reset), .bus(bus4), .fsm_state(st4));

    logic [15:0] exp_q1[$];
    logic [15:0] exp_q2[$];
    logic [15:0] exp_q4[$];
    logic [15:0] m_mem [256];
    bit          m_clear;
    int          m_clr_n;
    logic        m_err;
    logic [15:0] m_cnt;
    int          tests = 0;
    int          fails = 0;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        wren_ram    = 1'b0;
        address_ram = 16'd0;
        data_ram    = 16'd0;
        peek_addr   = 16'd0;
        #1;
        check("rst_q1", bus1.q_ram, 16'd0);
        check("rst_q2", bus2.q_ram, 16'd0);
        check("rst_q4", bus4.q_ram, 16'd0);
        check("rst_ready", {15'd0, bus2.ready}, 16'd0);
        check("rst_err", {15'd0, bus2.err}, 16'd0);
        check("rst_count", bus2.write_count, 16'd0);
        check("rst_peek", bus2.peek_data, 16'd0);
        m_clear = 1'b1;
        m_clr_n = 0;
        m_err   = 1'b0;
        m_cnt   = 16'd0;
        for (int i = 0; i < 256; i++) m_mem[i] = 16'd0;
        exp_q1.delete();
        exp_q2.delete();
        exp_q4.delete();
        exp_q2.push_back(16'd0);
        repeat (3) exp_q4.push_back(16'd0);
        @(negedge clock);
        reset = 1'b0;
    endtask

    // One clock of CPU traffic: predict this edge's results, push them, then compare after the edge.
    task automatic step(input logic [15:0] a, input logic w, input logic [15:0] d, input logic [15:0] p);
        logic [15:0] exp_rd;
        logic [15:0] exp_pk;
        bit a_ok;
        bit p_ok;
        address_ram = a;
        wren_ram    = w;
        data_ram    = d;
        peek_addr   = p;
        a_ok = (a < 16'h0100);
        p_ok = (p < 16'h0100);
        exp_rd = 16'd0;
        exp_pk = 16'd0;
        if (m_clear) begin
            if (w) m_err = 1'b1;
            m_clr_n++;
            if (m_clr_n == 256) m_clear = 1'b0;
        end else begin
            if (!a_ok) m_err = 1'b1;
            if (w && a_ok) begin
                m_mem[a[7:0]] = d;
                if (m_cnt != 16'hffff) m_cnt = m_cnt + 16'd1;
            end
            exp_rd = a_ok ? m_mem[a[7:0]] : 16'd0;
            exp_pk = p_ok ? m_mem[p[7:0]] : 16'd0;
        end
        @(posedge clock);
        exp_q1.push_back(exp_rd);
        exp_q2.push_back(exp_rd);
        exp_q4.push_back(exp_rd);
        #1;
        check("ready", {15'd0, bus2.ready}, {15'd0, !m_clear});
        check("err", {15'd0, bus2.err}, {15'd0, m_err});
        check("write_count", bus2.write_count, m_cnt);
        check("peek_data", bus2.peek_data, exp_pk);
        check("q_lat1", bus1.q_ram, exp_q1.pop_front());
        check("q_lat2", bus2.q_ram, exp_q2.pop_front());
        check("q_lat4", bus4.q_ram, exp_q4.pop_front());
    endtask

    task automatic idle(input int n);
        repeat (n) step(16'd0, 1'b0, 16'd0, 16'd0);
    endtask

    task automatic finish_clear();
        while (m_clear) step(16'($urandom_range(0, 255)), 1'b0, 16'($urandom), 16'($urandom_range(0, 255)));
    endtask

    initial begin
        #2;
        do_reset();
        finish_clear();
        for (int i = 0; i < 256; i++) step(16'd0, 1'b0, 16'd0, 16'(i));

        step(16'h0005, 1'b1, 16'h1234, 16'd0);
        step(16'h0005, 1'b0, 16'd0, 16'h0005);
        idle(4);

        step(16'h0010, 1'b1, 16'h0001, 16'd0);
        step(16'h0010, 1'b1, 16'hbeef, 16'h0010);
        step(16'h0010, 1'b0, 16'd0, 16'h0010);
        idle(4);

        for (int i = 0; i < 200; i++) begin
            step(16'($urandom_range(0, 63)), 1'($urandom_range(0, 1)), 16'($urandom),
                 16'($urandom_range(0, 63)));
        end
        idle(4);

        step(16'h0100, 1'b1, 16'h5555, 16'h0000);
        step(16'h0100, 1'b0, 16'd0, 16'h0000);
        idle(4);
        for (int i = 0; i < 100; i++) begin
            step(16'($urandom_range(0, 511)), 1'($urandom_range(0, 1)), 16'($urandom),
                 16'($urandom_range(0, 300)));
        end

        do_reset();
        idle(9);
        step(16'h0003, 1'b1, 16'haaaa, 16'h0003);
        finish_clear();
        step(16'd0, 1'b0, 16'd0, 16'h0003);
        idle(2);

        step(16'h0020, 1'b1, 16'h7777, 16'h0020);
        idle(2);
        do_reset();
        idle(50);
        do_reset();
        finish_clear();
        step(16'h0020, 1'b0, 16'd0, 16'h0020);
        for (int i = 0; i < 50; i++) begin
            step(16'($urandom_range(0, 63)), 1'($urandom_range(0, 1)), 16'($urandom),
                 16'($urandom_range(0, 63)));
        end
        step(16'h0020, 1'b1, 16'h7777, 16'h0020);
        do_reset();
        finish_clear();
        step(16'h0020, 1'b0, 16'd0, 16'h0020);
        step(16'h0005, 1'b1, 16'h1234, 16'd0);
        step(16'h0005, 1'b0, 16'd0, 16'h0005);
        idle(4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
